// File: rtl/sdram_pkg.sv
// Shared definitions for the SDRAM client blocks.
// Contents:
//   SDRAM_ADDR_W / SDRAM_DATA_W  - word address and data widths of sdram_ctl
//   DEF_READ_LATENCY             - default cycles from refresh_data rising to
//                                  the first valid word on sd_data_out
//   reader_state_t               - burst reader FSM states
package sdram_pkg;

  localparam int SDRAM_ADDR_W     = 25;
  localparam int SDRAM_DATA_W     = 16;
  localparam int DEF_READ_LATENCY = 4;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_CTL = 2'd1,
    FETCH    = 2'd2,
    FINISH   = 2'd3
  } reader_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock show-ahead FIFO.
// Ports:
//   clk, rst        - clock, asynchronous active-low reset (empties the FIFO)
//   push, push_data - write strobe and word; a push while full is dropped
//                     unless a pop happens in the same cycle
//   pop             - consume the head word; ignored while empty
//   pop_data        - head word, valid whenever empty is low
//   count           - number of stored words (0..DEPTH)
//   empty           - no words stored
// DEPTH must be a power of two so the pointers wrap naturally.
module sync_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             full;
  logic             pop_eff;
  logic             push_eff;

  assign empty    = (count == '0);
  assign full     = (count == CW'(DEPTH));
  assign pop_eff  = pop && !empty;
  // A full FIFO can still accept a word when the head leaves in the same cycle.
  assign push_eff = push && (!full || pop_eff);
  assign pop_data = mem[rd_ptr];

  // NOTE: the storage array has no reset; count/pointers alone define
  // which entries are valid, so clearing the data would only cost area.
  always_ff @(posedge clk) begin
    if (push_eff) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // NOTE: sequential state is updated with <= so every register samples
  // values from before the edge, independent of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_eff) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop_eff) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push_eff, pop_eff})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/sdram_burst_reader.sv
// Block reader in front of sdram_ctl. A request (start address, word count)
// is turned into one or more burst reads; returned words land in a local
// show-ahead FIFO for the downstream consumer. When the FIFO is about to fill
// the burst is stopped and later re-issued at the first address not yet read.
// Ports:
//   clk, rst            - clock, asynchronous active-low reset (aborts any
//                         request and discards buffered words)
//   req_valid/req_ready - request handshake; ready only while idle
//   req_addr, req_len   - first word address and word count (0 = no-op)
//   rd_valid, rd_data   - FIFO head (show-ahead)
//   rd_pop              - consume head; ignored while rd_valid is low
//   busy                - a request is in progress
//   done                - one-cycle pulse after the last word is captured
//   sd_addr             - burst start address, held for the whole burst
//   sd_write_en         - tied 0 (read-only client)
//   sd_data_in          - tied 0
//   sd_burst_en         - tied 1 (always burst mode)
//   sd_refresh_data     - burst run (1) / stop (0)
//   sd_data_out         - word stream from sdram_ctl
//   sd_data_ready       - sdram_ctl idle and able to start a burst
module sdram_burst_reader
  import sdram_pkg::*;
#(
  parameter int FIFO_DEPTH   = 16,
  parameter int READ_LATENCY = DEF_READ_LATENCY,
  parameter int RESTART_GAP  = 2,
  parameter int LEN_W        = 12
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [SDRAM_ADDR_W-1:0] req_addr,
  input  logic [LEN_W-1:0]        req_len,
  output logic                    rd_valid,
  output logic [SDRAM_DATA_W-1:0] rd_data,
  input  logic                    rd_pop,
  output logic                    busy,
  output logic                    done,
  output logic [SDRAM_ADDR_W-1:0] sd_addr,
  output logic                    sd_write_en,
  output logic [SDRAM_DATA_W-1:0] sd_data_in,
  output logic                    sd_burst_en,
  output logic                    sd_refresh_data,
  input  logic [SDRAM_DATA_W-1:0] sd_data_out,
  input  logic                    sd_data_ready
);

  localparam int CW    = $clog2(FIFO_DEPTH) + 1;
  localparam int LAT_W = $clog2(READ_LATENCY + 2);
  localparam int GAP_W = $clog2(RESTART_GAP + 2);

  reader_state_t state, state_next;

  logic [SDRAM_ADDR_W-1:0] cur_addr;
  logic [SDRAM_ADDR_W-1:0] burst_addr;
  logic [LEN_W-1:0]        remaining;
  logic [LAT_W-1:0]        lat_cnt;
  logic [GAP_W-1:0]        gap_cnt;
  logic                    done_q;

  logic [CW-1:0] fifo_count;
  logic          fifo_empty;

  logic accept_req;
  logic start_req;
  logic zero_req;
  logic pop_eff;
  logic capture;
  logic last_word;
  logic fifo_stop;
  logic stop;
  logic gap_ok;
  logic room_ok;
  logic start_burst;

  assign accept_req = (state == IDLE) && req_valid;
  assign start_req  = accept_req && (req_len != '0);
  assign zero_req   = accept_req && (req_len == '0);
  assign pop_eff    = rd_pop && !fifo_empty;

  // lat_cnt saturates at READ_LATENCY; from then on every FETCH cycle
  // carries a valid word from the controller.
  assign capture   = (state == FETCH) && (lat_cnt == LAT_W'(READ_LATENCY));
  assign last_word = (remaining == LEN_W'(1));

  // This capture would leave zero free slots once this cycle's pop is
  // accounted for; the burst must stop so the next word is not lost.
  // A capture never sees a full FIFO, so count <= FIFO_DEPTH-1 here.
  assign fifo_stop = !pop_eff && (fifo_count == CW'(FIFO_DEPTH - 1));
  assign stop      = capture && (last_word || fifo_stop);

  // Two free slots are required to restart, so a burst always delivers
  // at least one word before it can be throttled again.
  assign gap_ok      = (gap_cnt >= GAP_W'(RESTART_GAP));
  assign room_ok     = (fifo_count <= CW'(FIFO_DEPTH - 2));
  assign start_burst = (state == WAIT_CTL) && sd_data_ready && gap_ok && room_ok;

  // --------------------------------------------------------------------
  // FSM
  // --------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // NOTE: state_next gets its default before the case, so every path
  // assigns it and no latch is inferred.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (start_req) begin
          state_next = WAIT_CTL;
        end
      end
      WAIT_CTL: begin
        if (start_burst) begin
          state_next = FETCH;
        end
      end
      FETCH: begin
        if (stop) begin
          state_next = last_word ? FINISH : WAIT_CTL;
        end
      end
      FINISH: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------
  // Datapath registers
  // --------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cur_addr   <= '0;
      burst_addr <= '0;
      remaining  <= '0;
      lat_cnt    <= '0;
      // Start satisfied so the first burst after reset is not delayed.
      gap_cnt    <= GAP_W'(RESTART_GAP);
      done_q     <= 1'b0;
    end else begin
      done_q <= zero_req || (stop && last_word);

      if (start_req) begin
        cur_addr  <= req_addr;
        remaining <= req_len;
      end else if (capture) begin
        // Wraps modulo 2^SDRAM_ADDR_W by plain truncation.
        cur_addr  <= cur_addr + SDRAM_ADDR_W'(1);
        remaining <= remaining - LEN_W'(1);
      end

      // sd_addr must stay at the burst start while cur_addr advances.
      if (start_burst) begin
        burst_addr <= cur_addr;
      end

      if (state != FETCH) begin
        lat_cnt <= '0;
      end else if (lat_cnt != LAT_W'(READ_LATENCY)) begin
        lat_cnt <= lat_cnt + LAT_W'(1);
      end

      // gap_cnt counts cycles with refresh_data low since a throttled stop.
      if (stop && !last_word) begin
        gap_cnt <= '0;
      end else if ((state != FETCH) && !gap_ok) begin
        gap_cnt <= gap_cnt + GAP_W'(1);
      end
    end
  end

  // --------------------------------------------------------------------
  // Word buffer
  // --------------------------------------------------------------------
  sync_fifo #(
    .WIDTH (SDRAM_DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (capture),
    .push_data (sd_data_out),
    .pop       (rd_pop),
    .pop_data  (rd_data),
    .count     (fifo_count),
    .empty     (fifo_empty)
  );

  // --------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------
  assign req_ready       = (state == IDLE);
  assign busy            = (state != IDLE);
  assign done            = done_q;
  assign rd_valid        = !fifo_empty;
  assign sd_refresh_data = (state == FETCH);
  assign sd_addr         = burst_addr;
  assign sd_write_en     = 1'b0;
  assign sd_data_in      = '0;
  assign sd_burst_en     = 1'b1;

endmodule
